proj_sweep_ctrl: RTL and testbench
==================================

Name: proj_sweep_ctrl

Overview:
- Sequences exhaustive evaluation of a 17-input, 1-output combinational logic cone (x0..x16 -> y0) under a projection.
- Selected variables are swept through all assignments. The rest are held at a fixed base vector.
- Accumulates ones-count, a constant-function flag pair and a MISR signature of the cone output.
- Sits between the test/analysis host and the cone instance, so projection reducibility is checked in hardware rather than by simulation.

Parameters:
- N_IN, 17, number of cone inputs
- SETTLE_CYC, 1, extra cycles each vector is held before y is sampled (0..15)
- CNT_W, 18, width of ones-count; must be >= N_IN+1

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin sweep; sampled only in IDLE
- abort  input  1  terminate sweep; return to IDLE with no done
- base_vec  input  N_IN  values for non-swept inputs; captured at start
- free_mask  input  N_IN  1 = variable swept; captured at start
- eval_x  output  N_IN  vector driven to cone inputs x0..x(N_IN-1)
- eval_y  input  1  cone output y0
- busy  output  1  sweep in progress
- done  output  1  one-cycle pulse at sweep completion
- ones_count  output  CNT_W  number of evaluated vectors with y=1
- const_zero  output  1  all sampled y were 0
- const_one  output  1  all sampled y were 1
- signature  output  16  MISR over sampled y sequence

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; eval_x=0; busy=0; done=0; ones_count=0; const_zero=0; const_one=0; signature=16'hFFFF.
- States: IDLE, DRIVE, SAMPLE, FINISH.
- IDLE:
  - On start=1, capture base_vec/free_mask, clear sweep counter, ones_count=0, const_zero=1, const_one=1, signature=16'hFFFF.
  - Go to DRIVE. busy=1 from the next cycle.
- Vector formation:
  - eval_x = (base_vec & ~free_mask) | deposit(counter, free_mask).
  - deposit places counter bit i at the position of the i-th set bit of free_mask, LSB first.
  - k = popcount(free_mask); counter runs 0 .. 2^k-1. eval_x is registered.
- DRIVE: hold the vector SETTLE_CYC cycles (0 = skip straight to SAMPLE).
- SAMPLE: one cycle; eval_y sampled at the end of this cycle with the vector still applied. Updates:
  - ones_count += eval_y
  - const_zero &= ~eval_y
  - const_one &= eval_y
  - signature <= {signature[14:0], signature[15]^signature[13]^signature[12]^signature[10]^eval_y}
- After SAMPLE:
  - If counter == 2^k-1, go to FINISH.
  - Else counter+1, load the new eval_x, go to DRIVE.
- Each vector occupies exactly SETTLE_CYC+1 cycles. busy stays high for 2^k*(SETTLE_CYC+1) cycles.
- FINISH: one cycle; done=1, busy=0; go to IDLE. Results hold until the next start or reset.
- Boundary conditions:
  - free_mask=0: single evaluation of base_vec (k=0).
  - free_mask all ones: 2^17 evaluations; ones_count max 131072 fits CNT_W=18; counter must not wrap before terminal detect.
  - Bits of base_vec under free_mask are ignored.
  - start while busy: ignored. start in the FINISH cycle: ignored (accepted in IDLE only).
  - abort while busy: next cycle state=IDLE, busy=0, no done pulse. Results are partial and undefined-use; const flags are forced to 0.
  - abort and start together in IDLE: abort wins, start is dropped.
  - abort in the same cycle as the final SAMPLE: abort wins, no done.
  - rst_n low mid-sweep: immediate return to reset values. No done pulse.
  - eval_x is the only output driving the cone. It holds its last vector in IDLE; it is not cleared except by reset.

Test Plan:
1. Stub y=x0; SETTLE_CYC=1; base_vec=0, free_mask=0, pulse start.
   - busy high exactly 2 cycles; eval_x=0.
   - done pulse; ones_count=0, const_zero=1, const_one=0.
   - signature = 16'hFFFE (bit0 = 1^1^1^1^0 = 0).
2. Stub y=x0&x1; free_mask=17'h00003, base_vec=17'h1FFFC.
   - eval_x sequence 1FFFC,1FFFD,1FFFE,1FFFF.
   - ones_count=1, both const flags 0; busy 8 cycles.
3. Stub y=1; free_mask=17'h1FFFF, SETTLE_CYC=0.
   - 131072 busy cycles; ones_count=131072, const_one=1, const_zero=0.
4. Stub y=x16; free_mask=17'h10001 (x0,x16), base=0.
   - eval_x sequence 00000,00001,10000,10001.
   - ones_count=2.
   - Signature matches a reference model of the MISR over y sequence 0,0,1,1.
5. Start sweep with free_mask=17'h000FF; assert abort in cycle 10.
   - busy=0 next cycle, no done, const flags 0.
   - New start then completes normally with ones_count matching a fresh run.
6. Drop rst_n mid-sweep (cycle 5) asynchronously.
   - All outputs at reset values immediately, signature=16'hFFFF.
   - start pulses during busy in a later run are ignored: done exactly once.

Source files
------------

// File: rtl/proj_sweep_ctrl.sv
// proj_sweep_ctrl
// ---------------
// Drives a combinational cone exhaustively under a projection. Variables
// selected by free_mask are swept through every assignment. All other inputs
// are held at base_vec. Each sampled cone output is folded into a ones count,
// a pair of constant-function flags and a 16-bit MISR signature.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start                 begin a sweep; accepted only in IDLE
//   abort                 stop a sweep; return to IDLE without a done pulse
//   base_vec, free_mask   captured on an accepted start
//   eval_x                registered vector applied to the cone inputs
//   eval_y                cone output
//   busy, done            sweep in progress / one-cycle completion pulse
//   ones_count            number of sampled vectors with eval_y = 1
//   const_zero/const_one  every sampled eval_y was 0 / was 1
//   signature             MISR over the sampled eval_y sequence
//   dbg_state             current FSM state (IDLE=0, DRIVE=1, SAMPLE=2, FINISH=3)
//
// Handshake: start is a request taken in IDLE only, and abort takes priority
// over it. An accepted request raises busy on the following cycle. busy stays
// high until the sweep ends. A normal end gives a single done cycle, after
// which the results hold until the next accepted start. abort during busy
// ends the sweep on the next cycle with no done pulse.

module proj_sweep_ctrl #(
  parameter int N_IN       = 17,
  parameter int SETTLE_CYC = 1,
  parameter int CNT_W      = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [N_IN-1:0]  base_vec,
  input  logic [N_IN-1:0]  free_mask,
  output logic [N_IN-1:0]  eval_x,
  input  logic             eval_y,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] ones_count,
  output logic             const_zero,
  output logic             const_one,
  output logic [15:0]      signature,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    FINISH = 2'd3
  } state_e;

  // With no settle time a new vector is sampled in the very next cycle.
  localparam state_e     VEC_ENTRY   = (SETTLE_CYC == 0) ? SAMPLE : DRIVE;
  localparam logic [3:0] SETTLE_LAST = (SETTLE_CYC > 0) ? 4'(SETTLE_CYC - 1) : 4'd0;

  state_e          state_q, state_d;
  logic [N_IN-1:0] fixed_q;    // base_vec with the swept positions cleared
  logic [N_IN-1:0] mask_q;
  logic [N_IN-1:0] cnt_q;      // sweep counter, 0 .. 2^k-1
  logic [3:0]      settle_q;

  logic            start_acc;
  logic            sample_fire;
  logic            abort_busy;
  logic            is_last;
  logic [N_IN-1:0] cnt_next;
  logic [N_IN-1:0] next_vec;

  // Scatter the low bits of val onto the set positions of msk, LSB first.
  function automatic logic [N_IN-1:0] deposit(input logic [N_IN-1:0] val,
                                              input logic [N_IN-1:0] msk);
    logic [N_IN-1:0] r;
    int              j;
    r = '0;
    j = 0;
    for (int i = 0; i < N_IN; i++) begin
      if (msk[i]) begin
        r[i] = val[j];
        j    = j + 1;
      end
    end
    return r;
  endfunction

  // The terminal count 2^k-1 deposits to exactly the mask. This check does
  // not need k and it cannot wrap, even when all N_IN inputs are swept.
  assign is_last  = (deposit(cnt_q, mask_q) == mask_q);
  assign cnt_next = cnt_q + {{(N_IN-1){1'b0}}, 1'b1};
  assign next_vec = fixed_q | deposit(cnt_next, mask_q);

  assign busy      = (state_q == DRIVE) || (state_q == SAMPLE);
  assign done      = (state_q == FINISH);
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    start_acc   = 1'b0;
    sample_fire = 1'b0;
    abort_busy  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          start_acc = 1'b1;
          state_d   = VEC_ENTRY;
        end
      end
      DRIVE: begin
        if (abort) begin
          abort_busy = 1'b1;
          state_d    = IDLE;
        end else if (settle_q == SETTLE_LAST) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        if (abort) begin
          abort_busy = 1'b1;
          state_d    = IDLE;
        end else begin
          sample_fire = 1'b1;
          state_d     = is_last ? FINISH : VEC_ENTRY;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Settle timer restarts every time DRIVE is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_q <= 4'd0;
    end else if (state_q == DRIVE) begin
      settle_q <= settle_q + 4'd1;
    end else begin
      settle_q <= 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fixed_q    <= '0;
      mask_q     <= '0;
      cnt_q      <= '0;
      eval_x     <= '0;
      ones_count <= '0;
      const_zero <= 1'b0;
      const_one  <= 1'b0;
      signature  <= 16'hFFFF;
    end else if (start_acc) begin
      fixed_q    <= base_vec & ~free_mask;
      mask_q     <= free_mask;
      cnt_q      <= '0;
      eval_x     <= base_vec & ~free_mask;   // counter 0 deposits nothing
      ones_count <= '0;
      const_zero <= 1'b1;
      const_one  <= 1'b1;
      signature  <= 16'hFFFF;
    end else if (sample_fire) begin
      ones_count <= ones_count + {{(CNT_W-1){1'b0}}, eval_y};
      const_zero <= const_zero & ~eval_y;
      const_one  <= const_one & eval_y;
      signature  <= {signature[14:0],
                     signature[15] ^ signature[13] ^ signature[12] ^ signature[10] ^ eval_y};
      if (!is_last) begin
        cnt_q  <= cnt_next;
        eval_x <= next_vec;
      end
    end else if (abort_busy) begin
      // Partial results of an aborted sweep must not look like a constant function.
      const_zero <= 1'b0;
      const_one  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_proj_sweep_ctrl.sv
module tb_proj_sweep_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Main instance: 17 inputs, one settle cycle.
  logic        start, abort;
  logic [16:0] base_vec, free_mask, eval_x;
  logic        eval_y, busy, done, const_zero, const_one;
  logic [17:0] ones_count;
  logic [15:0] signature;
  logic [1:0]  dbg_state;

  // Second instance: 12 inputs, no settle cycles. It gives a full-mask sweep short enough to run.
  logic        s_start, s_abort;
  logic [11:0] s_base, s_mask, s_eval_x;
  logic        s_eval_y, s_busy, s_done, s_cz, s_co;
  logic [12:0] s_ones;
  logic [15:0] s_sig;
  logic [1:0]  s_dbg;

  proj_sweep_ctrl #(.N_IN(17), .SETTLE_CYC(1), .CNT_W(18)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .base_vec(base_vec), .free_mask(free_mask), .eval_x(eval_x), .eval_y(eval_y),
    .busy(busy), .done(done), .ones_count(ones_count), .const_zero(const_zero),
    .const_one(const_one), .signature(signature), .dbg_state(dbg_state)
  );

  proj_sweep_ctrl #(.N_IN(12), .SETTLE_CYC(0), .CNT_W(13)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(s_start), .abort(s_abort),
    .base_vec(s_base), .free_mask(s_mask), .eval_x(s_eval_x), .eval_y(s_eval_y),
    .busy(s_busy), .done(s_done), .ones_count(s_ones), .const_zero(s_cz),
    .const_one(s_co), .signature(s_sig), .dbg_state(s_dbg)
  );

  // ---------------- cone stubs ----------------
  int          stub_mode;
  logic [16:0] stub_key;

  function automatic logic stub_y(input int mode, input logic [16:0] key, input logic [16:0] x);
    case (mode)
      0:       return x[0];
      1:       return x[0] & x[1];
      2:       return 1'b1;
      3:       return x[16];
      default: return (^(x & key)) ^ (x[3] & x[2]);
    endcase
  endfunction

  assign eval_y   = stub_y(stub_mode, stub_key, eval_x);
  assign s_eval_y = stub_y(stub_mode, stub_key, {5'b0, s_eval_x});

  // Select which instance the monitor observes.
  bit          use0;
  logic        mon_busy, mon_done, mon_cz, mon_co;
  logic [16:0] mon_x;
  logic [17:0] mon_ones;
  logic [15:0] mon_sig;
  assign mon_busy = use0 ? s_busy : busy;
  assign mon_done = use0 ? s_done : done;
  assign mon_cz   = use0 ? s_cz : const_zero;
  assign mon_co   = use0 ? s_co : const_one;
  assign mon_x    = use0 ? {5'b0, s_eval_x} : eval_x;
  assign mon_ones = use0 ? {5'b0, s_ones} : ones_count;
  assign mon_sig  = use0 ? s_sig : signature;

  // ---------------- scoreboard ----------------
  int          tests_run, tests_failed;
  logic [16:0] exp_q[$];
  int          exp_ones, exp_busy;
  logic        exp_cz, exp_co;
  logic [15:0] exp_sig;

  // Reference: the vectors are every value that agrees with base outside the
  // mask, in ascending order. The swept part is stepped through the submasks.
  task automatic model(input logic [16:0] b, input logic [16:0] m, input int settle);
    logic [16:0] s, v;
    logic        y;
    exp_q.delete();
    exp_ones = 0; exp_cz = 1'b1; exp_co = 1'b1; exp_sig = 16'hFFFF;
    s = '0;
    do begin
      v = (b & ~m) | s;
      exp_q.push_back(v);
      y = stub_y(stub_mode, stub_key, v);
      exp_ones = exp_ones + int'(y);
      exp_cz   = exp_cz & ~y;
      exp_co   = exp_co & y;
      exp_sig  = {exp_sig[14:0], exp_sig[15] ^ exp_sig[13] ^ exp_sig[12] ^ exp_sig[10] ^ y};
      s = (s - m) & m;
    end while (s != 17'd0);
    exp_busy = exp_q.size() * (settle + 1);
  endtask

  // One full sweep on the selected instance, checked against the model.
  task automatic run_sweep(input logic [16:0] b, input logic [16:0] m, input bit inject);
    int          settle, bcnt, dcnt, done_at;
    logic [16:0] ev;
    settle = use0 ? 0 : 1;
    bcnt = 0; dcnt = 0; done_at = -1;
    model(b, m, settle);
    @(negedge clk);
    if (use0) begin s_base = b[11:0]; s_mask = m[11:0]; s_start = 1'b1; end
    else begin base_vec = b; free_mask = m; start = 1'b1; end
    @(negedge clk);
    start = 1'b0; s_start = 1'b0;
    for (int c = 0; c <= exp_busy + 2; c++) begin
      if (mon_busy) begin
        if (bcnt % (settle + 1) == 0) begin
          tests_run++;
          if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL vector_extra: got %05h required none", mon_x);
          end else begin
            ev = exp_q.pop_front();
            if (mon_x !== ev) begin
              tests_failed++;
              $display("FAIL vector: got %05h required %05h", mon_x, ev);
            end
          end
        end
        bcnt++;
      end
      if (mon_done) begin
        dcnt++;
        if (done_at < 0) done_at = c;
      end
      // Stray starts during busy and in the done cycle must be ignored.
      if (inject && !use0) start = (mon_busy && ($urandom_range(0, 2) == 0)) || mon_done;
      @(negedge clk);
    end
    start = 1'b0;
    tests_run++;
    if (bcnt !== exp_busy) begin tests_failed++; $display("FAIL busy_cycles: got %0d required %0d", bcnt, exp_busy); end
    tests_run++;
    if (dcnt !== 1 || done_at !== exp_busy) begin
      tests_failed++; $display("FAIL done_pulse: got count %0d at %0d required 1 at %0d", dcnt, done_at, exp_busy);
    end
    tests_run++;
    if (exp_q.size() != 0) begin tests_failed++; $display("FAIL vectors_missing: got %0d left required 0", exp_q.size()); end
    tests_run++;
    if (mon_ones !== 18'(exp_ones)) begin tests_failed++; $display("FAIL ones_count: got %0d required %0d", mon_ones, exp_ones); end
    tests_run++;
    if (mon_cz !== exp_cz || mon_co !== exp_co) begin
      tests_failed++; $display("FAIL const_flags: got %b%b required %b%b", mon_cz, mon_co, exp_cz, exp_co);
    end
    tests_run++;
    if (mon_sig !== exp_sig) begin tests_failed++; $display("FAIL signature: got %04h required %04h", mon_sig, exp_sig); end
  endtask

  // ---------------- scenarios ----------------
  task automatic check_reset_values();
    tests_run++;
    if (eval_x !== 17'd0 || busy !== 1'b0 || done !== 1'b0 || ones_count !== 18'd0 ||
        const_zero !== 1'b0 || const_one !== 1'b0 || signature !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL reset_values: got x=%05h busy=%b done=%b ones=%0d cz=%b co=%b sig=%04h required all zero, sig=ffff",
               eval_x, busy, done, ones_count, const_zero, const_one, signature);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    check_reset_values();
    tests_run++;
    if (s_busy !== 1'b0 || s_ones !== 13'd0 || s_sig !== 16'hFFFF) begin
      tests_failed++; $display("FAIL reset_values_small: got busy=%b ones=%0d sig=%04h required 0 0 ffff", s_busy, s_ones, s_sig);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    use0 = 0; stub_mode = 0;
    run_sweep(17'h00000, 17'h00000, 0);
    tests_run++;
    if (signature !== 16'hFFFE || const_zero !== 1'b1 || const_one !== 1'b0 || eval_x !== 17'd0) begin
      tests_failed++; $display("FAIL single_eval: got sig=%04h cz=%b co=%b x=%05h required fffe 1 0 00000", signature, const_zero, const_one, eval_x);
    end
  endtask

  task automatic test_pair();
    use0 = 0; stub_mode = 1;
    run_sweep(17'h1FFFC, 17'h00003, 0);
    tests_run++;
    if (ones_count !== 18'd1) begin tests_failed++; $display("FAIL pair_ones: got %0d required 1", ones_count); end
  endtask

  task automatic test_full_mask();
    use0 = 1; stub_mode = 2;
    run_sweep(17'h00000, 17'h00FFF, 0);
    tests_run++;
    if (s_ones !== 13'd4096 || s_co !== 1'b1 || s_cz !== 1'b0) begin
      tests_failed++; $display("FAIL full_mask: got ones=%0d co=%b cz=%b required 4096 1 0", s_ones, s_co, s_cz);
    end
    use0 = 0;
  endtask

  task automatic test_x16();
    use0 = 0; stub_mode = 3;
    run_sweep(17'h00000, 17'h10001, 0);
    tests_run++;
    if (ones_count !== 18'd2) begin tests_failed++; $display("FAIL x16_ones: got %0d required 2", ones_count); end
  endtask

  task automatic test_random();
    logic [16:0] b, m;
    int          w;
    for (int i = 0; i < 6; i++) begin
      use0 = i[0];
      w = use0 ? 12 : 17;
      stub_mode = 4;
      stub_key  = 17'($urandom);
      m = '0;
      repeat ($urandom_range(0, 6)) m[$urandom_range(0, w - 1)] = 1'b1;
      b = 17'($urandom);
      if (use0) b = b & 17'h00FFF;
      run_sweep(b, m, 0);
    end
    use0 = 0;
  endtask

  task automatic test_abort();
    int dcnt;
    use0 = 0; stub_mode = 4; stub_key = 17'($urandom);
    @(negedge clk);
    base_vec = 17'($urandom); free_mask = 17'h000FF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 10; c++) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || const_zero !== 1'b0 || const_one !== 1'b0) begin
      tests_failed++; $display("FAIL abort_mid: got busy=%b done=%b cz=%b co=%b required 0 0 0 0", busy, done, const_zero, const_one);
    end
    dcnt = 0;
    for (int c = 0; c < 4; c++) begin
      if (done) dcnt++;
      @(negedge clk);
    end
    tests_run++;
    if (dcnt !== 0) begin tests_failed++; $display("FAIL abort_no_done: got %0d required 0", dcnt); end

    // abort together with start in IDLE: the start is dropped
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL abort_start_idle: got busy=%b required 0", busy); end

    // abort in the final SAMPLE cycle (single vector: DRIVE then SAMPLE)
    free_mask = 17'h00000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || const_zero !== 1'b0 || const_one !== 1'b0) begin
      tests_failed++; $display("FAIL abort_last_sample: got busy=%b done=%b cz=%b co=%b required 0 0 0 0", busy, done, const_zero, const_one);
    end

    run_sweep(17'($urandom), 17'h000FF, 0);
  endtask

  task automatic test_reset_mid();
    use0 = 0; stub_mode = 4; stub_key = 17'($urandom);
    @(negedge clk);
    base_vec = 17'h1FF00; free_mask = 17'h000FF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 5; c++) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_values();
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep(17'($urandom), 17'h00029, 1);
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    start = 0; abort = 0; base_vec = '0; free_mask = '0;
    s_start = 0; s_abort = 0; s_base = '0; s_mask = '0;
    stub_mode = 0; stub_key = '0; use0 = 0;
    test_reset();
    test_single();
    test_pair();
    test_full_mask();
    test_x16();
    test_random();
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
